axi_memory_slave_nrd: RTL

AXI_MEMORY_SLAVE_NRD -- requirements
Module: axi_memory_slave_nrd

---
 rtl/axi_memory_slave_nrd.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_memory_slave_nrd.sv
// Word-addressed AXI-style memory slave: one burst write port, NUM_RD
// independent burst read ports, all running concurrently.
module axi_memory_slave_nrd #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 1024,
    parameter int NUM_RD      = 3,
    parameter int INIT_OPTION = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         wvalid,
    input  logic                         wlast,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] araddr,
    input  logic [NUM_RD*8-1:0]          arlen,
    input  logic [NUM_RD-1:0]            arvalid,
    output logic [NUM_RD-1:0]            arready,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rvalid,
    output logic [NUM_RD-1:0]            rlast,
    input  logic [NUM_RD-1:0]            rready
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_BURST} r_state_e;

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) ? mem_q[a[IDX_W-1:0]] : '0;
    endfunction

    // Handshake readies stay low until the first edge after reset release
    logic live_q;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_end, w_inr, w_err, mem_we;

    assign w_end = (wcnt_q == wlen_q);
    assign w_inr = in_range(waddr_q);
    assign w_err = werr_q | ~w_inr | (wlast ^ w_end);

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        awready   = live_q && (w_state_q == W_IDLE);
        wready    = (w_state_q == W_DATA);
        bvalid    = (w_state_q == W_RESP);
        bresp     = bresp_q;
        unique case (w_state_q)
            W_IDLE: if (awvalid && awready) begin
                waddr_d   = awaddr;
                wlen_d    = awlen;
                wcnt_d    = '0;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid) begin
                mem_we  = w_inr;
                waddr_d = waddr_q + 1'b1;
                wcnt_d  = wcnt_q + 8'd1;
                werr_d  = w_err;
                if (wlast || w_end) begin
                    bresp_d   = w_err ? 2'b10 : 2'b00;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_SIZE; i++)
                mem_q[i] <= (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
        end else if (mem_we) begin
            mem_q[waddr_q[IDX_W-1:0]] <= wdata;
        end
    end

    r_state_e              r_q [NUM_RD];
    r_state_e              r_d [NUM_RD];
    logic [ADDR_WIDTH-1:0] raddr_q [NUM_RD];
    logic [ADDR_WIDTH-1:0] raddr_d [NUM_RD];
    logic [7:0]            rlen_q [NUM_RD];
    logic [7:0]            rlen_d [NUM_RD];
    logic [7:0]            rcnt_q [NUM_RD];
    logic [7:0]            rcnt_d [NUM_RD];
    logic [DATA_WIDTH-1:0] rdat_q [NUM_RD];
    logic [DATA_WIDTH-1:0] rdat_d [NUM_RD];
    logic                  rlst_q [NUM_RD];
    logic                  rlst_d [NUM_RD];

    // rd() sees pre-edge memory, so same-edge writes are not visible
    always_comb begin
        arready = '0;
        rvalid  = '0;
        rlast   = '0;
        rdata   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            r_d[i]     = r_q[i];
            raddr_d[i] = raddr_q[i];
            rlen_d[i]  = rlen_q[i];
            rcnt_d[i]  = rcnt_q[i];
            rdat_d[i]  = rdat_q[i];
            rlst_d[i]  = rlst_q[i];
            arready[i] = live_q && (r_q[i] == R_IDLE);
            rvalid[i]  = (r_q[i] == R_BURST);
            rlast[i]   = rlst_q[i];
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdat_q[i];
            unique case (r_q[i])
                R_IDLE: if (arvalid[i] && arready[i]) begin
                    raddr_d[i] = araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    rlen_d[i]  = arlen[i*8 +: 8];
                    rcnt_d[i]  = '0;
                    rdat_d[i]  = rd(araddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
                    rlst_d[i]  = (arlen[i*8 +: 8] == 8'd0);
                    r_d[i]     = R_BURST;
                end
                R_BURST: if (rready[i]) begin
                    if (rlst_q[i]) begin
                        rlst_d[i] = 1'b0;
                        r_d[i]    = R_IDLE;
                    end else begin
                        raddr_d[i] = raddr_q[i] + 1'b1;
                        rcnt_d[i]  = rcnt_q[i] + 8'd1;
                        rdat_d[i]  = rd(raddr_q[i] + 1'b1);
                        rlst_d[i]  = ((rcnt_q[i] + 8'd1) == rlen_q[i]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++) begin
                r_q[i]     <= R_IDLE;
                raddr_q[i] <= '0;
                rlen_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                rdat_q[i]  <= '0;
                rlst_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                r_q[i]     <= r_d[i];
                raddr_q[i] <= raddr_d[i];
                rlen_q[i]  <= rlen_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                rdat_q[i]  <= rdat_d[i];
                rlst_q[i]  <= rlst_d[i];
            end
        end
    end

endmodule
